// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the 4-digit seven-segment scan controller.
//   DIGITS       : number of multiplexed digits
//   AN_OFF       : anode pattern with every digit dark (anodes are active low)
//   scan_state_t : per-slot phase, BLANK (anti-ghosting gap) or DRIVE
//   digit_idx_t  : index of the digit currently being scanned
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int         DIGITS = 4;
   localparam logic [3:0] AN_OFF = 4'b1111;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/display_scan_if.sv
// ---------------------------------------------------------------------------
// display_scan_if
// Bundles the control/data inputs and display outputs of display_scan.
//   master : the host side (drives en/load/value/dp_in, observes the display)
//   slave  : the scan controller itself
// Signals:
//   en, load, value[15:0], dp_in[3:0]           host -> controller
//   nibble[3:0], an[3:0], dp, frame_tick, pend  controller -> host/board
// ---------------------------------------------------------------------------
interface display_scan_if;

   logic        en;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;
   logic        pend;

   modport master (
      output en, load, value, dp_in,
      input  nibble, an, dp, frame_tick, pend
   );

   modport slave (
      input  en, load, value, dp_in,
      output nibble, an, dp, frame_tick, pend
   );

endinterface

// File: rtl/display_scan_slot_timer.sv
// ---------------------------------------------------------------------------
// slot_timer
// Per-digit slot counter for display_scan. Counts 0..CLK_DIV-1 while en is
// high and holds otherwise. Lookahead flags describe the count that will be
// present after the next edge so the parent can register its outputs in step
// with the counter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         count enable
//   wrap       current count is CLK_DIV-1 and will wrap on this edge
//   blank_nxt  next count is inside the blanking window (< BLANK_CYC)
//   last_nxt   next count is the final count of the slot (CLK_DIV-1)
// ---------------------------------------------------------------------------
module slot_timer #(
   parameter int CLK_DIV   = 1024,
   parameter int BLANK_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic wrap,
   output logic blank_nxt,
   output logic last_nxt
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;

   // Next count, wrap detection and lookahead phase flags.
   always_comb begin
      cnt_next_s = cnt_r;
      wrap       = 1'b0;
      if (en) begin
         if (cnt_r == CNT_MAX) begin
            wrap       = 1'b1;
            cnt_next_s = '0;
         end else begin
            cnt_next_s = cnt_r + CNT_ONE;
         end
      end else begin
         cnt_next_s = cnt_r;
      end
      blank_nxt = (cnt_next_s < CNT_BLANK);
      last_nxt  = (cnt_next_s == CNT_MAX);
   end

   // Slot counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

endmodule

// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. One digit is selected per slot of CLK_DIV cycles; the first
// BLANK_CYC cycles of each slot keep every anode off to stop ghosting, while
// the digit's nibble is already presented to the hex decoder. New values are
// double-buffered and only take effect at a frame boundary.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       display_scan_if.slave: en, load, value, dp_in (in);
//             nibble, an (active low), dp (active low), frame_tick, pend (out)
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (with no decimal
//                          point at or above them) are kept dark; digit 0 is
//                          always shown.
// ---------------------------------------------------------------------------
module display_scan
   import display_pkg::*;
#(
   parameter int CLK_DIV   = 1024,
   parameter int BLANK_CYC = 16
) (
   input  logic           clk,
   input  logic           rst,
   display_scan_if.slave  bus
);

   logic        wrap_s;
   logic        blank_nxt_s;
   logic        last_nxt_s;

   digit_idx_t  idx_r;
   digit_idx_t  idx_next_s;
   scan_state_t state_r;
   scan_state_t state_next_s;
   logic        frame_end_s;

   logic [15:0] act_val_r;
   logic [3:0]  act_dp_r;
   logic [15:0] act_val_next_s;
   logic [3:0]  act_dp_next_s;
   logic [15:0] pend_val_r;
   logic [3:0]  pend_dp_r;
   logic [15:0] pend_val_next_s;
   logic [3:0]  pend_dp_next_s;
   logic        pend_r;
   logic        pend_next_s;

   logic [3:0]  an_r;
   logic        dp_r;
   logic [3:0]  nibble_r;
   logic        tick_r;
   logic [3:0]  an_next_s;
   logic        dp_next_s;
   logic [3:0]  nibble_next_s;
   logic        tick_next_s;
   logic        show_s;
`ifdef LEADING_ZERO_BLANK_EN
   logic        upper_zero_s;
`endif

   slot_timer #(
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_slot_timer (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .wrap      (wrap_s),
      .blank_nxt (blank_nxt_s),
      .last_nxt  (last_nxt_s)
   );

   // Digit index advance and double-buffer transfer at the frame boundary.
   always_comb begin
      frame_end_s     = wrap_s && (idx_r == 2'd3);
      idx_next_s      = wrap_s ? (idx_r + 2'd1) : idx_r;
      act_val_next_s  = act_val_r;
      act_dp_next_s   = act_dp_r;
      pend_val_next_s = pend_val_r;
      pend_dp_next_s  = pend_dp_r;
      pend_next_s     = pend_r;
      if (frame_end_s) begin
         // A load landing on the boundary bypasses the pending buffer.
         pend_next_s = 1'b0;
         if (bus.load) begin
            act_val_next_s = bus.value;
            act_dp_next_s  = bus.dp_in;
         end else if (pend_r) begin
            act_val_next_s = pend_val_r;
            act_dp_next_s  = pend_dp_r;
         end else begin
            act_val_next_s = act_val_r;
            act_dp_next_s  = act_dp_r;
         end
      end else if (bus.load) begin
         pend_val_next_s = bus.value;
         pend_dp_next_s  = bus.dp_in;
         pend_next_s     = 1'b1;
      end else begin
         pend_next_s = pend_r;
      end
   end

   // Leading-zero suppression for the digit that will be scanned next.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((i >= int'(idx_next_s)) &&
             ((act_val_next_s[i*4 +: 4] != 4'h0) || act_dp_next_s[i])) begin
            upper_zero_s = 1'b0;
         end else begin
            upper_zero_s = upper_zero_s;
         end
      end
      show_s = !(upper_zero_s && (idx_next_s != 2'd0));
`else
      show_s = 1'b1;
`endif
   end

   // FSM next state and next registered outputs, all derived from the
   // post-edge position so an/nibble/dp switch together with the counter.
   always_comb begin
      state_next_s  = state_r;
      an_next_s     = AN_OFF;
      dp_next_s     = 1'b1;
      nibble_next_s = nibble_r;
      tick_next_s   = 1'b0;
      if (bus.en) begin
         state_next_s  = blank_nxt_s ? BLANK : DRIVE;
         nibble_next_s = act_val_next_s[{idx_next_s, 2'b00} +: 4];
         tick_next_s   = last_nxt_s && (idx_next_s == 2'd3);
         case (state_next_s)
            BLANK: begin
               an_next_s = AN_OFF;
               dp_next_s = 1'b1;
            end
            DRIVE: begin
               if (show_s) begin
                  an_next_s = ~(4'b0001 << idx_next_s);
                  dp_next_s = ~act_dp_next_s[idx_next_s];
               end else begin
                  an_next_s = AN_OFF;
                  dp_next_s = 1'b1;
               end
            end
            default: begin
               an_next_s = AN_OFF;
               dp_next_s = 1'b1;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // FSM state and digit index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= BLANK;
         idx_r   <= 2'd0;
      end else begin
         state_r <= state_next_s;
         idx_r   <= idx_next_s;
      end
   end

   // Active and pending display buffers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_val_r  <= 16'h0000;
         act_dp_r   <= 4'h0;
         pend_val_r <= 16'h0000;
         pend_dp_r  <= 4'h0;
         pend_r     <= 1'b0;
      end else begin
         act_val_r  <= act_val_next_s;
         act_dp_r   <= act_dp_next_s;
         pend_val_r <= pend_val_next_s;
         pend_dp_r  <= pend_dp_next_s;
         pend_r     <= pend_next_s;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r     <= AN_OFF;
         dp_r     <= 1'b1;
         nibble_r <= 4'h0;
         tick_r   <= 1'b0;
      end else begin
         an_r     <= an_next_s;
         dp_r     <= dp_next_s;
         nibble_r <= nibble_next_s;
         tick_r   <= tick_next_s;
      end
   end

   assign bus.an         = an_r;
   assign bus.dp         = dp_r;
   assign bus.nibble     = nibble_r;
   assign bus.frame_tick = tick_r;
   assign bus.pend       = pend_r;

endmodule

// File: tb/tb_display_scan.sv
// ---------------------------------------------------------------------------
// tb_display_scan
// Self-checking bench for display_scan with CLK_DIV=8, BLANK_CYC=2.
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_display_scan;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   display_scan_if bus_if();

   display_scan #(
      .CLK_DIV   (8),
      .BLANK_CYC (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpi;
      logic [3:0]  lit_lz;   // digits lit when leading-zero blanking is built in
   } row_t;

   row_t rows[6];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_tick(input string name, output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(negedge clk);
         n++;
         if (bus_if.frame_tick === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s: frame_tick not seen within 64 cycles", name);
      end
   endtask

   // Starts just before the cycle after a frame boundary; ends on the next frame_tick cycle.
   task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] dpi,
                              input logic [3:0] lit, input logic exp_pend);
      logic [3:0] exp_an;
      logic       exp_dp;
      logic [3:0] dig;
      for (int d = 0; d < 4; d++) begin
         dig    = val[d*4 +: 4];
         exp_an = lit[d] ? ~(4'b0001 << d) : 4'b1111;
         exp_dp = lit[d] ? ~dpi[d] : 1'b1;
         @(negedge clk);
         chk($sformatf("%s_d%0d_blank_an", tag, d), bus_if.an, 4'b1111);
         chk($sformatf("%s_d%0d_blank_nib", tag, d), bus_if.nibble, dig);
         chk($sformatf("%s_d%0d_blank_dp", tag, d), bus_if.dp, 1'b1);
         if (d == 0) chk($sformatf("%s_pend", tag), bus_if.pend, exp_pend);
         repeat (2) @(negedge clk);
         chk($sformatf("%s_d%0d_drive_an", tag, d), bus_if.an, exp_an);
         chk($sformatf("%s_d%0d_drive_nib", tag, d), bus_if.nibble, dig);
         chk($sformatf("%s_d%0d_drive_dp", tag, d), bus_if.dp, exp_dp);
         repeat (5) @(negedge clk);
         chk($sformatf("%s_d%0d_end_an", tag, d), bus_if.an, exp_an);
         chk($sformatf("%s_d%0d_tick", tag, d), bus_if.frame_tick, (d == 3));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rows[0] = '{val: 16'h1234, dpi: 4'b0000, lit_lz: 4'b1111};
      rows[1] = '{val: 16'hABCD, dpi: 4'b0100, lit_lz: 4'b1111};
      rows[2] = '{val: 16'h0050, dpi: 4'b0000, lit_lz: 4'b0011};
      rows[3] = '{val: 16'h0000, dpi: 4'b0000, lit_lz: 4'b0001};
      rows[4] = '{val: 16'h0000, dpi: 4'b0100, lit_lz: 4'b0111};
      rows[5] = '{val: 16'hF00F, dpi: 4'b1001, lit_lz: 4'b1111};

      bus_if.en    = 1'b0;
      bus_if.load  = 1'b0;
      bus_if.value = 16'h0000;
      bus_if.dp_in = 4'h0;
      rst          = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_an", bus_if.an, 4'b1111);
      chk("rst_dp", bus_if.dp, 1'b1);
      chk("rst_nibble", bus_if.nibble, 4'h0);
      chk("rst_tick", bus_if.frame_tick, 1'b0);
      chk("rst_pend", bus_if.pend, 1'b0);
      rst       = 1'b0;
      bus_if.en = 1'b1;

      // Table: load in one frame, expect it displayed in the following one.
      for (int i = 0; i < 6; i++) begin
         if (i != 0) @(negedge clk);
         bus_if.value = rows[i].val;
         bus_if.dp_in = rows[i].dpi;
         bus_if.load  = 1'b1;
         @(negedge clk);
         bus_if.load  = 1'b0;
         chk($sformatf("row%0d_pend_set", i), bus_if.pend, 1'b1);
         wait_tick($sformatf("row%0d_tick", i), n);
         check_frame($sformatf("row%0d", i), rows[i].val, rows[i].dpi,
                     LZ ? rows[i].lit_lz : 4'b1111, 1'b0);
      end

      // Mid-frame load (digit 1 slot): old value F00F stays until the boundary.
      repeat (12) @(negedge clk);
      bus_if.value = 16'hABCD;
      bus_if.dp_in = 4'b0000;
      bus_if.load  = 1'b1;
      @(negedge clk);
      bus_if.load  = 1'b0;
      chk("mid_pend", bus_if.pend, 1'b1);
      chk("mid_d1_an", bus_if.an, 4'b1101);
      chk("mid_d1_nib", bus_if.nibble, 4'h0);
      repeat (6) @(negedge clk);
      chk("mid_d2_nib", bus_if.nibble, 4'h0);
      repeat (8) @(negedge clk);
      chk("mid_d3_nib", bus_if.nibble, 4'hF);
      repeat (5) @(negedge clk);
      chk("mid_tick", bus_if.frame_tick, 1'b1);
      chk("mid_pend_held", bus_if.pend, 1'b1);
      check_frame("mid", 16'hABCD, 4'b0000, 4'b1111, 1'b0);

      // Two loads in one frame: last one wins.
      @(negedge clk);
      bus_if.value = 16'h1111;
      bus_if.load  = 1'b1;
      @(negedge clk);
      bus_if.load  = 1'b0;
      repeat (2) @(negedge clk);
      bus_if.value = 16'h2222;
      bus_if.load  = 1'b1;
      @(negedge clk);
      bus_if.load  = 1'b0;
      chk("lastwins_pend", bus_if.pend, 1'b1);
      wait_tick("lastwins_tick", n);
      check_frame("lastwins", 16'h2222, 4'b0000, 4'b1111, 1'b0);

      // Load coinciding with frame_tick: goes straight to active, pend stays low.
      bus_if.value = 16'h3333;
      bus_if.load  = 1'b1;
      @(posedge clk);
      #1 bus_if.load = 1'b0;
      check_frame("coinc", 16'h3333, 4'b0000, 4'b1111, 1'b0);
      wait_tick("period_tick", n);
      chk("frame_period", n, 32);

      // Pause scanning for 10 cycles in digit-1 DRIVE, then resume in place.
      repeat (13) @(negedge clk);
      chk("pause_pre_an", bus_if.an, 4'b1101);
      bus_if.en = 1'b0;
      @(negedge clk);
      chk("pause_an", bus_if.an, 4'b1111);
      chk("pause_dp", bus_if.dp, 1'b1);
      repeat (9) @(negedge clk);
      chk("pause_tick", bus_if.frame_tick, 1'b0);
      chk("pause_an_late", bus_if.an, 4'b1111);
      bus_if.en = 1'b1;
      @(negedge clk);
      chk("resume_an", bus_if.an, 4'b1101);
      chk("resume_nib", bus_if.nibble, 4'h3);
      wait_tick("resume_tick", n);
      chk("resume_to_tick", n, 18);

      // Asynchronous reset between edges during digit-2 DRIVE.
      repeat (21) @(negedge clk);
      chk("prerst_an", bus_if.an, 4'b1011);
      #2 rst = 1'b1;
      #1;
      chk("arst_an", bus_if.an, 4'b1111);
      chk("arst_nib", bus_if.nibble, 4'h0);
      chk("arst_dp", bus_if.dp, 1'b1);
      chk("arst_pend", bus_if.pend, 1'b0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_blank_an", bus_if.an, 4'b1111);
      @(negedge clk);
      chk("post_rst_d0_an", bus_if.an, 4'b1110);
      chk("post_rst_d0_nib", bus_if.nibble, 4'h0);
      wait_tick("post_rst_tick", n);
      chk("post_rst_to_tick", n, 29);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
